// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcode/cond/ALU encodings and field positions for dp_controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int CLASS_HI = 27;
    localparam int CLASS_LO = 26;
    localparam int I_BIT    = 25;
    localparam int OP_HI    = 24;
    localparam int OP_LO    = 21;
    localparam int S_BIT    = 20;
    localparam int RN_HI    = 19;
    localparam int RN_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int SH_HI    = 6;
    localparam int SH_LO    = 5;
    localparam int RM_HI    = 3;
    localparam int RM_LO    = 0;

    // Unsupported condition codes never pass, so they retire as NOPs
    function automatic logic cond_pass(input logic [3:0] cond, input logic z);
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode for dp_controller
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic        is_mov,
    output logic        is_cmp,
    output logic        needs_write
);

    logic [3:0] opcode;
    assign opcode = instr[OP_HI:OP_LO];

    // Map opcode to ALU function; anything outside the data-processing subset is illegal
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_AND:  alu_op = ALU_AND;
            OP_EOR:  alu_op = ALU_EOR;
            OP_SUB:  alu_op = ALU_SUB;
            OP_ADD:  alu_op = ALU_ADD;
            OP_CMP:  alu_op = ALU_SUB;
            OP_ORR:  alu_op = ALU_ORR;
            OP_MOV:  alu_op = ALU_ADD;
            default: illegal = 1'b1;
        endcase
        if (instr[CLASS_HI:CLASS_LO] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    assign is_mov      = (opcode == OP_MOV);
    assign is_cmp      = (opcode == OP_CMP);
    assign needs_write = ~is_cmp & ~illegal;

endmodule

// File: rtl/dp_controller.sv
// rtl/dp_controller.sv - multi-cycle datapath control FSM (optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt until reset)
module dp_controller
    import ctrl_pkg::*;
#(
    parameter bit S_BIT_HONOUR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        status_in,
    output logic        waiting,
    output logic        done,
    output logic [31:0] dp_in,
    output logic        wb_sel,
    output logic [3:0]  w_addr,
    output logic        w_en,
    output logic [3:0]  r_addr,
    output logic        en_A,
    output logic        en_B,
    output logic        en_C,
    output logic        en_status,
    output logic [1:0]  shift_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic [2:0]  ALU_op,
    output logic        illegal
);

    state_t      state;
    logic [31:0] instr_q;

    logic [2:0]  dec_alu_op;
    logic        dec_illegal;
    logic        dec_is_mov;
    logic        dec_is_cmp;
    logic        dec_needs_write;
    logic        pass;
    logic        imm;

    ctrl_decode u_decode (
        .instr       (instr_q),
        .alu_op      (dec_alu_op),
        .illegal     (dec_illegal),
        .is_mov      (dec_is_mov),
        .is_cmp      (dec_is_cmp),
        .needs_write (dec_needs_write)
    );

    assign pass = cond_pass(instr_q[COND_HI:COND_LO], status_in);
    assign imm  = instr_q[I_BIT];

    // State sequencing and instruction capture; reset drops any in-flight instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_WAIT;
            instr_q <= 32'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (start) begin
                        instr_q <= instr;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state <= ST_HALT;
`else
                        state <= ST_WAIT;
`endif
                    end else if (!pass) begin
                        state <= ST_WAIT;
                    end else if (dec_is_mov) begin
                        state <= imm ? ST_EXEC : ST_LOAD_B;
                    end else begin
                        state <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: state <= imm ? ST_EXEC : ST_LOAD_B;
                ST_LOAD_B: state <= ST_EXEC;
                ST_EXEC:   state <= dec_needs_write ? ST_WB : ST_WAIT;
                ST_WB:     state <= ST_WAIT;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_WAIT;
            endcase
        end
    end

    // Decode every datapath strobe from the current state and latched instruction
    always_comb begin
        waiting   = (state == ST_WAIT);
        done      = 1'b0;
        illegal   = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        w_en      = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        ALU_op    = 3'b000;
        wb_sel    = 1'b0;
        w_addr    = instr_q[RD_HI:RD_LO];
        r_addr    = (state == ST_LOAD_B) ? instr_q[RM_HI:RM_LO] : instr_q[RN_HI:RN_LO];
        dp_in     = {20'd0, instr_q[11:0]};
        shift_op  = imm ? 2'b00 : instr_q[SH_HI:SH_LO];
        case (state)
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
`ifndef CTRL_ILLEGAL_TRAP_EN
                    done    = 1'b1;
`endif
                end else if (!pass) begin
                    done = 1'b1;
                end
            end
            ST_LOAD_A: en_A = 1'b1;
            ST_LOAD_B: en_B = 1'b1;
            ST_EXEC: begin
                en_C      = 1'b1;
                ALU_op    = dec_alu_op;
                sel_A     = dec_is_mov;
                sel_B     = imm;
                en_status = dec_is_cmp | (S_BIT_HONOUR & instr_q[S_BIT]);
                done      = ~dec_needs_write;
            end
            ST_WB: begin
                w_en = 1'b1;
                done = 1'b1;
            end
            ST_HALT: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
